// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, defaults and width helper for the uart receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= INIT;
      q    <= INIT;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_err,
`ifdef UART_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = cnt_width(WIDTH + 1);
  localparam logic [CW-1:0] CNT_HALF    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(WIDTH - 1);

  logic             rx_s;
  uart_state_e      state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n, frame_err_n;
`ifdef UART_RX_PARITY_EN
  logic             par_bit, par_bit_n;
  logic             parity_err_n;
`endif

  sync_2ff #(.INIT(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shreg      <= shreg_n;
      data       <= data_n;
      valid      <= valid_n;
      frame_err  <= frame_err_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    idx_n        = idx;
    shreg_n      = shreg;
    data_n       = data;
    valid_n      = 1'b0;
    frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    parity_err_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (cnt == CNT_HALF) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_BIT_END) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[WIDTH-1:1]};
          idx_n   = idx + 1'b1;
          if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_BIT_END) begin
          cnt_n     = '0;
          par_bit_n = rx_s;
          state_n   = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == CNT_BIT_END) begin
          cnt_n = '0;
          // A low stop bit wins over any parity result.
          if (!rx_s) begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (^{shreg, par_bit}) begin
            parity_err_n = 1'b1;
            state_n      = IDLE;
`endif
          end else begin
            data_n  = shreg;
            valid_n = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not read as 0x00 frames.
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx; define UART_RX_PARITY_EN to cover parity
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int W   = 8;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         rx    = 1'b1;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         busy;
`ifdef UART_RX_PARITY_EN
  logic         parity_err;
`endif

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  logic [W-1:0] exp_q[$];
  logic valid_d = 1'b0;
  logic ferr_d  = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("exp_q_depth_at_valid", exp_q.size(), 1);
      else check("rx_data", int'(data), int'(exp_q.pop_front()));
      check("valid_width", int'(valid_d), 0);
      check("valid_vs_ferr", int'(frame_err), 0);
    end
    if (frame_err) begin
      n_ferr++;
      check("ferr_width", int'(ferr_d), 0);
    end
`ifdef UART_RX_PARITY_EN
    if (parity_err) begin
      n_perr++;
      check("perr_vs_valid", int'(valid), 0);
    end
`endif
    valid_d = valid;
    ferr_d  = frame_err;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] b, input logic stop_bit,
                            input logic par_bit, input bit expect_ok);
    if (expect_ok) exp_q.push_back(b);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) rx = 1'b1;
`endif
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, p0, waited;
    logic [W-1:0] c3;
    c3 = 8'hC3;

    repeat (3) @(negedge clk);
    check("rst_data", int'(data), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b0;
    idle_bits(1);

    // single frame
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
    idle_bits(1);
    check("a5_valid_cnt", n_valid - v0, 1);
    check("a5_ferr_cnt", n_ferr - f0, 0);
    check("a5_data_hold", int'(data), 'hA5);
    check("a5_busy_after", int'(busy), 0);

    // back-to-back with one stop bit
    v0 = n_valid;
    send_frame(8'h00, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check("b2b_valid_cnt", n_valid - v0, 2);
    check("b2b_data_hold", int'(data), 'hFF);

    // glitch shorter than half a bit
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_busy_low", int'(busy), 0);
    idle_bits(2);
    check("glitch_valid_cnt", n_valid - v0, 0);
    check("glitch_ferr_cnt", n_ferr - f0, 0);

    // bad stop bit followed by a held-low line
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    check("ferr_cnt", n_ferr - f0, 1);
    check("ferr_valid_cnt", n_valid - v0, 0);
    check("ferr_data_kept", int'(data), 'hFF);
    check("ferr_busy_held", int'(busy), 1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("ferr_busy_release", int'(busy), 0);
    idle_bits(1);
    v0 = n_valid;
    send_frame(8'h81, 1'b1, ^8'h81, 1'b1);
    idle_bits(1);
    check("after_ferr_valid_cnt", n_valid - v0, 1);
    check("after_ferr_data", int'(data), 'h81);

    // reset in the middle of data bit 4
    v0 = n_valid; f0 = n_ferr;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(c3[i]);
    rx = c3[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_data", int'(data), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_ferr", int'(frame_err), 0);
    check("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    idle_bits(10);
    check("midrst_no_strobe", (n_valid - v0) + (n_ferr - f0), 0);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1'b1);
    idle_bits(1);
    check("midrst_next_cnt", n_valid - v0, 1);
    check("midrst_next_data", int'(data), 'h5A);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("par_bad_perr_cnt", n_perr - p0, 1);
    check("par_bad_valid_cnt", n_valid - v0, 0);
    check("par_bad_data_kept", int'(data), 'h5A);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check("par_good_valid_cnt", n_valid - v0, 1);
    check("par_good_perr_cnt", n_perr - p0, 1);
    check("par_good_data", int'(data), 'h07);
`else
    p0 = n_perr;
    check("noparity_perr_cnt", n_perr - p0, 0);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that deserializes 8N1 (optionally 8E1) frames from an asynchronous rx pin into parallel words.
- Sits directly upstream of the team's data-holding latch: `data` drives the latch `in`, and `valid` drives the latch `set`.
- A received byte is captured in the latch on the clock edge after `valid` pulses.

Parameters:
- WIDTH, 8, number of data bits per frame, LSB first.
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Legal range is CLKS_PER_BIT >= 4.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  WIDTH  last successfully received word; holds between frames.
- valid  output  1  one-cycle strobe; data is new and good this cycle.
- frame_err  output  1  one-cycle strobe; stop bit sampled low.
- busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - On reset: data=0, valid=0, frame_err=0, busy=0, state=IDLE, synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame with no strobe.
- Input synchronizer: rx passes through a 2-flop synchronizer. rx_s denotes the second flop. All sampling uses rx_s, so there are 2 cycles of input latency.
- Bit counter: width $clog2(CLKS_PER_BIT). Index counter: width $clog2(WIDTH+1). Shift register: WIDTH bits, filled LSB first by right-shift insertion at the MSB.
- States:
  - IDLE:
    - busy=0.
    - On rx_s==0, go to START, clear the bit counter, set busy=1.
  - START:
    - Count to CLKS_PER_BIT/2-1, i.e. the mid-start-bit point.
    - If rx_s==1 there, treat it as a glitch: go to IDLE with no strobe.
    - Otherwise clear the counter and index, and go to DATA.
  - DATA:
    - Count to CLKS_PER_BIT-1, then sample rx_s into the shift register and increment the index.
    - After WIDTH samples, go to STOP (or to PARITY when the optional feature is compiled in).
  - STOP:
    - Count to CLKS_PER_BIT-1, then sample rx_s.
    - If 1: data <= shift register, valid=1 for exactly the next cycle, go to IDLE.
    - If 0: frame_err=1 for one cycle, data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH:
    - busy stays 1.
    - Stay in this state until rx_s==1, then go to IDLE. This prevents a break condition from being decoded as back-to-back 0x00 frames.
- Outputs:
  - valid and frame_err are mutually exclusive. Neither is ever high for more than 1 cycle.
- Timing:
  - A new start bit is accepted in the cycle after returning to IDLE.
  - Back-to-back frames with a 1-bit stop must decode with no lost frame.
  - Total latency, from the rx falling edge at the pin to valid, is 2 + CLKS_PER_BIT/2 + (WIDTH+1)*CLKS_PER_BIT + 1 cycles, ±1.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, which samples one bit after CLKS_PER_BIT cycles.
  - Even parity check: XOR of data bits and the parity bit must be 0.
  - Adds output port parity_err (1 bit), a one-cycle strobe issued at STOP completion in place of valid when parity fails. In that case data is not updated.
  - If the stop bit is also bad, frame_err takes priority and parity_err stays 0.
- Undefined:
  - No PARITY state and no parity_err port; the frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - state enum IDLE/START/DATA/PARITY/STOP/WAIT_HIGH, 3-bit encoding;
  - localparam DEFAULT_CLKS_PER_BIT=434;
  - function for counter width.
- One natural sub-module: sync_2ff, a 2-flop synchronizer with reset value parameter INIT=1, reusable for other async inputs.

Test Plan:
- Bench CLKS_PER_BIT=16: send 0xA5 as 8N1 -> valid for exactly 1 cycle, data=0xA5, frame_err=0, busy low afterwards.
- Send 0x00 then 0xFF back-to-back with 1 stop bit -> two valid pulses, data=0x00 then 0xFF, no missed frame.
- Pulse rx low for 4 cycles (less than CLKS_PER_BIT/2) -> glitch rejected; no valid, no frame_err; busy returns to 0 within 10 cycles.
- Send 0x3C with stop bit forced 0 and rx held low 40 cycles -> frame_err pulses once, data retains previous value, busy stays 1 until rx high, then the next frame 0x81 decodes correctly.
- Assert reset during DATA bit 4 -> all outputs 0 on the next cycle, no strobe; a subsequent frame 0x5A decodes correctly.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 (wrong) -> parity_err=1 for one cycle, valid=0. Send it again with parity 1 -> valid=1, data=0x07.
